// File: rtl/main_memory_ctrl.sv
// Block-granular backing store behind the L2: whole-block reads/writes that
// complete after a fixed access latency with a one-cycle mem_ready pulse.
module main_memory_ctrl #(
    parameter int unsigned             DATA_WIDTH = 8,
    parameter int unsigned             ADDR_WIDTH = 4,
    parameter int unsigned             BLOCK_SIZE = 4,
    parameter int unsigned             LATENCY    = 3,
    parameter logic [DATA_WIDTH-1:0]   INIT_BYTE  = 8'h00
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in,
    input  logic                             mem_read,
    input  logic                             mem_write,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_block,
    output logic                             mem_ready,
    output logic                             busy,
    output logic                             proto_err,
    output logic [15:0]                      read_count,
    output logic [15:0]                      write_count
);

    localparam int unsigned OFFSET_W   = $clog2(BLOCK_SIZE);
    localparam int unsigned IDX_W      = ADDR_WIDTH - OFFSET_W;
    localparam int unsigned IDX_SW     = (IDX_W > 0) ? IDX_W : 1;
    localparam int unsigned NUM_BLOCKS = (1 << ADDR_WIDTH) / BLOCK_SIZE;
    localparam int unsigned BLK_W      = BLOCK_SIZE * DATA_WIDTH;
    localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_SW-1:0]  idx_q;
    logic [BLK_W-1:0]   wdata_q;
    logic               is_write_q;
    logic               capture_c;
    logic               op_write_c;
    logic [IDX_SW-1:0]  op_idx_c;
    logic [BLK_W-1:0]   op_data_c;
    logic               commit_c;
    logic [BLK_W-1:0]   mem_q [NUM_BLOCKS];

    // Next-state, latency counter and effective-operation selection
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    capture_c = 1'b1;
                    cnt_d     = CNT_W'(LATENCY - 1);
                    state_d   = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // With LATENCY=1 the commit coincides with capture, so use live inputs then
        op_write_c = capture_c ? mem_write : is_write_q;
        op_idx_c   = capture_c ? IDX_SW'(mem_addr >> OFFSET_W) : idx_q;
        op_data_c  = capture_c ? mem_data_in : wdata_q;
        commit_c   = (state_d == RESP);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, registered status outputs, read data and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            wdata_q        <= '0;
            is_write_q     <= 1'b0;
            mem_ready      <= 1'b0;
            busy           <= 1'b0;
            proto_err      <= 1'b0;
            mem_data_block <= '0;
            read_count     <= '0;
            write_count    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            mem_ready <= commit_c;
            busy      <= (state_d != IDLE);
            proto_err <= capture_c && mem_read && mem_write;
            if (capture_c) begin
                idx_q      <= IDX_SW'(mem_addr >> OFFSET_W);
                wdata_q    <= mem_data_in;
                is_write_q <= mem_write;
            end
            if (commit_c) begin
                if (op_write_c) begin
                    write_count <= write_count + 16'd1;
                end else begin
                    read_count     <= read_count + 16'd1;
                    mem_data_block <= mem_q[op_idx_c];
                end
            end
        end
    end

    // Storage array; every byte returns to INIT_BYTE on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < int'(NUM_BLOCKS); b++) begin
                mem_q[b] <= {BLOCK_SIZE{INIT_BYTE}};
            end
        end else if (commit_c && op_write_c) begin
            mem_q[op_idx_c] <= op_data_c;
        end
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench: stimulus pushes expected completions into a queue, a monitor
// pops and compares on every mem_ready pulse.
module tb_main_memory_ctrl;

    localparam int unsigned BLK_W = 32;

    typedef struct {
        logic [BLK_W-1:0] data;
        logic [15:0]      rc;
        logic [15:0]      wc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       mem_addr = '0;
    logic [BLK_W-1:0] mem_data_in = '0;
    logic             mem_read = 1'b0;
    logic             mem_write = 1'b0;
    logic [BLK_W-1:0] mem_data_block;
    logic             mem_ready;
    logic             busy;
    logic             proto_err;
    logic [15:0]      read_count;
    logic [15:0]      write_count;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   proto_seen = 0;

    main_memory_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_data_block (mem_data_block),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .proto_err      (proto_err),
        .read_count     (read_count),
        .write_count    (write_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && proto_err) proto_seen++;
        if (!rst && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'(mem_ready), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ready_data", mem_data_block, e.data);
                check("ready_rcount", 32'(read_count), 32'(e.rc));
                check("ready_wcount", 32'(write_count), 32'(e.wc));
            end
        end
    end

    task automatic push(input logic [BLK_W-1:0] d, input logic [15:0] rc, input logic [15:0] wc);
        exp_t e;
        e.data = d; e.rc = rc; e.wc = wc;
        exp_q.push_back(e);
    endtask

    // Drive a request and hold it until ready, then release it
    task automatic do_req(input logic rd, input logic wr, input logic [3:0] a, input logic [BLK_W-1:0] d);
        bit seen = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_data_in = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_ready) seen = 1;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        // Reset state
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_rcount", 32'(read_count), 32'd0);
        check("rst_wcount", 32'(write_count), 32'd0);
        check("rst_data", mem_data_block, 32'h0);

        // Read of initialised block 1
        push(32'h0000_0000, 16'd1, 16'd0);
        do_req(1'b1, 1'b0, 4'h4, 32'h0);
        idle(3);

        // Write 0xB with cycle-exact busy/ready checks; capture edge follows this drive
        push(32'h0000_0000, 16'd1, 16'd1);
        mem_write = 1'b1; mem_addr = 4'hB; mem_data_in = 32'hBBBB_BBBB;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            check($sformatf("wr_ready_c%0d", cyc), 32'(mem_ready), (cyc == 4) ? 32'd1 : 32'd0);
            check($sformatf("wr_busy_c%0d", cyc), 32'(busy), (cyc <= 5) ? 32'd1 : 32'd0);
            if (cyc == 4) mem_write = 1'b0;
        end

        // Same-block read returns written data; other block still initial
        push(32'hBBBB_BBBB, 16'd2, 16'd1);
        do_req(1'b1, 1'b0, 4'h8, 32'h0);
        push(32'h0000_0000, 16'd3, 16'd1);
        do_req(1'b1, 1'b0, 4'hC, 32'h0);
        idle(3);

        // Read held 3 cycles past ready: ignored in TURN, one recapture in IDLE
        push(32'hBBBB_BBBB, 16'd4, 16'd1);
        push(32'hBBBB_BBBB, 16'd5, 16'd1);
        mem_read = 1'b1; mem_addr = 4'h8;
        for (int i = 0; i < 20 && !mem_ready; i++) @(negedge clk);
        idle(3);
        mem_read = 1'b0;
        idle(12);
        check("held_rcount", 32'(read_count), 32'd5);
        check("held_queue_drained", 32'(exp_q.size()), 32'd0);

        // Read+write together: treated as write, single proto_err pulse
        p0 = proto_seen;
        push(32'hBBBB_BBBB, 16'd5, 16'd2);
        do_req(1'b1, 1'b1, 4'h0, 32'hCCCC_CCCC);
        idle(3);
        check("proto_pulses", 32'(proto_seen - p0), 32'd1);
        push(32'hCCCC_CCCC, 16'd6, 16'd2);
        do_req(1'b1, 1'b0, 4'h0, 32'h0);
        idle(3);

        // Reset one cycle after capturing a write abandons it
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 4'h4; mem_data_in = 32'hAAAA_AAAA;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_write = 1'b0;
        #1;
        check("midrst_ready", 32'(mem_ready), 32'd0);
        idle(3);
        rst = 1'b0;
        idle(6);
        check("midrst_wcount", 32'(write_count), 32'd0);
        check("midrst_rcount", 32'(read_count), 32'd0);
        push(32'h0000_0000, 16'd1, 16'd0);
        do_req(1'b1, 1'b0, 4'h4, 32'h0);
        idle(4);
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
